// File: rtl/copy_sched_pkg.sv
// Shared job type, scheduler states and Avalon register map for the copy-engine job scheduler.
package copy_sched_pkg;

    localparam int JOB_SRC_W = 18;

    typedef struct packed {
        logic [9:0]           x_start;
        logic [9:0]           x_end;
        logic [9:0]           y_start;
        logic [9:0]           y_end;
        logic [JOB_SRC_W-1:0] src;
        logic [1:0]           palette;
        logic                 flip;
    } job_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RETIRE
    } sched_state_t;

    localparam logic [3:0] REG_X_START  = 4'd0;
    localparam logic [3:0] REG_X_END    = 4'd1;
    localparam logic [3:0] REG_Y_START  = 4'd2;
    localparam logic [3:0] REG_Y_END    = 4'd3;
    localparam logic [3:0] REG_SRC      = 4'd4;
    localparam logic [3:0] REG_PALETTE  = 4'd5;
    localparam logic [3:0] REG_FLIP     = 4'd6;
    localparam logic [3:0] REG_PUSH     = 4'd7;
    localparam logic [3:0] REG_STATUS   = 4'd8;
    localparam logic [3:0] REG_FLUSH    = 4'd9;
    localparam logic [3:0] REG_DONE_CNT = 4'd10;
    localparam logic [3:0] REG_CLR      = 4'd11;

    // Byte-lane merge used for the byte-enabled staging registers.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/copy_job_fifo.sv
// Synchronous show-ahead FIFO of copy jobs; a push into a full FIFO is accepted only with a same-cycle pop.
module copy_job_fifo
    import copy_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  job_t        push_job,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output job_t        head
);

    job_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_job;
        end
    end

endmodule

// File: rtl/copy_job_scheduler.sv
// Avalon-MM job queue that feeds the copy engine one job at a time and runs its execute/done handshake.
// Define COPY_SCHED_TIMEOUT_EN to add a per-job watchdog that aborts jobs stuck in RUN.
module copy_job_scheduler
    import copy_sched_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int SRC_W          = 18,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             AVL_READ,
    input  logic             AVL_WRITE,
    input  logic             AVL_CS,
    input  logic [3:0]       AVL_BYTE_EN,
    input  logic [3:0]       AVL_ADDR,
    input  logic [31:0]      AVL_WRITEDATA,
    output logic [31:0]      AVL_READDATA,
    output logic [9:0]       dest_x_start,
    output logic [9:0]       dest_x_end,
    output logic [9:0]       dest_y_start,
    output logic [9:0]       dest_y_end,
    output logic [SRC_W-1:0] src_addr_start,
    output logic [1:0]       palette_index,
    output logic             flip_x,
    output logic             engine_execute,
    input  logic             engine_done,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t         state;
    sched_state_t         state_next;
    job_t                 staged;
    job_t                 active;
    job_t                 fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 overflow_sticky;
    logic                 timeout_sticky;
    logic                 timeout_hit;
    logic                 done_inc;
    logic [15:0]          done_cnt;
    logic [31:0]          reg_word;
    logic [31:0]          status_word;
    logic [JOB_SRC_W-1:0] wr_merged;
    logic                 wr_en;
    logic                 push_req;
    logic                 flush_req;
    logic                 clr_req;
    logic                 done_clr;

    assign wr_en     = AVL_CS && AVL_WRITE;
    assign push_req  = wr_en && (AVL_ADDR == REG_PUSH);
    assign flush_req = wr_en && (AVL_ADDR == REG_FLUSH);
    assign clr_req   = wr_en && (AVL_ADDR == REG_CLR);
    assign done_clr  = wr_en && (AVL_ADDR == REG_DONE_CNT);

    copy_job_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push_req),
        .pop      (fifo_pop),
        .flush    (flush_req),
        .push_job (staged),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    // A flush aborts the running job without counting it; done wins over a same-cycle timeout.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        done_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !flush_req) begin
                    fifo_pop   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_next = RETIRE;
                end else if (engine_done) begin
                    state_next = RETIRE;
                    done_inc   = 1'b1;
                end else if (timeout_hit) begin
                    state_next = RETIRE;
                end
            end
            RETIRE: begin
                if (!engine_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            active <= '0;
        end else begin
            state <= state_next;
            if (fifo_pop) begin
                active <= fifo_head;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            staged          <= '0;
            overflow_sticky <= 1'b0;
            done_cnt        <= '0;
        end else begin
            if (wr_en) begin
                case (AVL_ADDR)
                    REG_X_START: staged.x_start <= wr_merged[9:0];
                    REG_X_END:   staged.x_end   <= wr_merged[9:0];
                    REG_Y_START: staged.y_start <= wr_merged[9:0];
                    REG_Y_END:   staged.y_end   <= wr_merged[9:0];
                    REG_SRC:     staged.src     <= wr_merged;
                    REG_PALETTE: staged.palette <= wr_merged[1:0];
                    REG_FLIP:    staged.flip    <= wr_merged[0];
                    default:     ;
                endcase
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow_sticky <= 1'b1;
            end else if (clr_req && AVL_WRITEDATA[3]) begin
                overflow_sticky <= 1'b0;
            end
            if (done_clr) begin
                done_cnt <= '0;
            end else if (done_inc) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

`ifdef COPY_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] run_cycles;

    always_ff @(posedge CLK) begin
        if (RESET || state != RUN) begin
            run_cycles <= '0;
        end else begin
            run_cycles <= run_cycles + TW'(1);
        end
    end

    assign timeout_hit = (state == RUN) && (run_cycles == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            timeout_sticky <= 1'b0;
        end else if (timeout_hit && !flush_req && !engine_done) begin
            timeout_sticky <= 1'b1;
        end else if (clr_req && AVL_WRITEDATA[4]) begin
            timeout_sticky <= 1'b0;
        end
    end
`else
    assign timeout_hit    = 1'b0;
    assign timeout_sticky = 1'b0;
`endif

    assign status_word = {16'd0, 8'(fifo_count), 3'd0, timeout_sticky,
                          overflow_sticky, busy, fifo_full, fifo_empty};

    // The same mux feeds readback and the old value for byte-enabled staging writes.
    always_comb begin
        reg_word = '0;
        case (AVL_ADDR)
            REG_X_START:  reg_word = 32'(staged.x_start);
            REG_X_END:    reg_word = 32'(staged.x_end);
            REG_Y_START:  reg_word = 32'(staged.y_start);
            REG_Y_END:    reg_word = 32'(staged.y_end);
            REG_SRC:      reg_word = 32'(staged.src);
            REG_PALETTE:  reg_word = 32'(staged.palette);
            REG_FLIP:     reg_word = 32'(staged.flip);
            REG_STATUS:   reg_word = status_word;
            REG_DONE_CNT: reg_word = 32'(done_cnt);
            default:      reg_word = '0;
        endcase
    end

    assign wr_merged    = JOB_SRC_W'(merge_bytes(reg_word, AVL_WRITEDATA, AVL_BYTE_EN));
    assign AVL_READDATA = (AVL_CS && AVL_READ) ? reg_word : '0;

    assign busy           = (state != IDLE) || !fifo_empty;
    assign engine_execute = (state == RUN);
    assign dest_x_start   = active.x_start;
    assign dest_x_end     = active.x_end;
    assign dest_y_start   = active.y_start;
    assign dest_y_end     = active.y_end;
    assign src_addr_start = SRC_W'(active.src);
    assign palette_index  = active.palette;
    assign flip_x         = active.flip;

endmodule

// File: tb/tb_copy_job_scheduler.sv
// Directed self-checking bench for copy_job_scheduler with a simple done-after-N-cycles engine model.
module tb_copy_job_scheduler;

    localparam int SRC_W = 18;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             AVL_READ = 1'b0;
    logic             AVL_WRITE = 1'b0;
    logic             AVL_CS = 1'b0;
    logic [3:0]       AVL_BYTE_EN = 4'h0;
    logic [3:0]       AVL_ADDR = 4'h0;
    logic [31:0]      AVL_WRITEDATA = 32'h0;
    logic [31:0]      AVL_READDATA;
    logic [9:0]       dest_x_start, dest_x_end, dest_y_start, dest_y_end;
    logic [SRC_W-1:0] src_addr_start;
    logic [1:0]       palette_index;
    logic             flip_x;
    logic             engine_execute;
    logic             engine_done = 1'b0;
    logic             busy;

    int n_checks = 0;
    int n_pass = 0;
    int eng_delay = 0;
    int exec_cnt = 0;
    int stable_errs = 0;
    int run_len = 0;
    int last_run_len = 0;
    logic        prev_exec = 1'b0;
    logic [60:0] prev_cfg = '0;
    logic [60:0] cfg;
    logic [9:0]  start_log [$];

    assign cfg = {dest_x_start, dest_x_end, dest_y_start, dest_y_end,
                  src_addr_start, palette_index, flip_x};

    copy_job_scheduler #(
        .DEPTH(16),
        .SRC_W(SRC_W),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .AVL_READ       (AVL_READ),
        .AVL_WRITE      (AVL_WRITE),
        .AVL_CS         (AVL_CS),
        .AVL_BYTE_EN    (AVL_BYTE_EN),
        .AVL_ADDR       (AVL_ADDR),
        .AVL_WRITEDATA  (AVL_WRITEDATA),
        .AVL_READDATA   (AVL_READDATA),
        .dest_x_start   (dest_x_start),
        .dest_x_end     (dest_x_end),
        .dest_y_start   (dest_y_start),
        .dest_y_end     (dest_y_end),
        .src_addr_start (src_addr_start),
        .palette_index  (palette_index),
        .flip_x         (flip_x),
        .engine_execute (engine_execute),
        .engine_done    (engine_done),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    // Engine raises done eng_delay cycles into execute and holds it until execute drops; 0 = stalled.
    always @(negedge CLK) begin
        if (RESET || !engine_execute || eng_delay == 0) begin
            engine_done = 1'b0;
            exec_cnt = 0;
        end else begin
            exec_cnt++;
            if (exec_cnt >= eng_delay) engine_done = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (prev_exec && engine_execute && cfg != prev_cfg) stable_errs++;
        if (engine_execute && !prev_exec) start_log.push_back(dest_x_start);
        if (engine_execute) begin
            run_len++;
        end else if (prev_exec) begin
            last_run_len = run_len;
            run_len = 0;
        end
        prev_exec = engine_execute;
        prev_cfg = cfg;
    end

    task automatic avl_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge CLK);
        AVL_CS = 1'b1;
        AVL_WRITE = 1'b1;
        AVL_ADDR = addr;
        AVL_WRITEDATA = data;
        AVL_BYTE_EN = be;
        @(negedge CLK);
        AVL_CS = 1'b0;
        AVL_WRITE = 1'b0;
        AVL_BYTE_EN = 4'h0;
    endtask

    task automatic avl_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge CLK);
        AVL_CS = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = addr;
        #1 data = AVL_READDATA;
        AVL_CS = 1'b0;
        AVL_READ = 1'b0;
    endtask

    task automatic stage_job(input int x0, input int x1, input int y0, input int y1,
                             input int src, input int pal, input int flip);
        avl_write(4'd0, 32'(x0), 4'hF);
        avl_write(4'd1, 32'(x1), 4'hF);
        avl_write(4'd2, 32'(y0), 4'hF);
        avl_write(4'd3, 32'(y1), 4'hF);
        avl_write(4'd4, 32'(src), 4'hF);
        avl_write(4'd5, 32'(pal), 4'hF);
        avl_write(4'd6, 32'(flip), 4'hF);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        n_checks++;
        if ({engine_execute, busy, cfg} !== '0)
            $display("[TB] FAIL reset_outputs: got exec=%b busy=%b cfg=%h expected all 0", engine_execute, busy, cfg);
        else n_pass++;
        @(negedge CLK);
        AVL_CS = 1'b1;
        AVL_ADDR = 4'd8;
        #1;
        n_checks++;
        if (AVL_READDATA !== 32'h0)
            $display("[TB] FAIL readdata_idle: got %h expected 00000000", AVL_READDATA);
        else n_pass++;
        AVL_CS = 1'b0;
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL reset_status: got %h expected 00000001", rd);
        else n_pass++;
        avl_read(4'd10, rd);
        n_checks++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_done_cnt: got %h expected 00000000", rd);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        avl_write(4'd0, 32'hFFFF_FFFF, 4'b0001);
        avl_read(4'd0, rd);
        n_checks++;
        if (rd !== 32'h0FF) $display("[TB] FAIL be_low_byte: got %h expected 000000ff", rd);
        else n_pass++;
        avl_write(4'd0, 32'h0000_0100, 4'b0010);
        avl_read(4'd0, rd);
        n_checks++;
        if (rd !== 32'h1FF) $display("[TB] FAIL be_second_byte: got %h expected 000001ff", rd);
        else n_pass++;
        avl_write(4'd4, 32'hFFFF_FFFF, 4'hF);
        avl_read(4'd4, rd);
        n_checks++;
        if (rd !== 32'h3FFFF) $display("[TB] FAIL src_width: got %h expected 0003ffff", rd);
        else n_pass++;
        avl_read(4'd12, rd);
        n_checks++;
        if (rd !== 32'h0) $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd);
        else n_pass++;
    endtask

    task automatic test_single_job();
        logic [31:0] rd;
        logic [6:0]  pat;
        logic [60:0] cfg_run;
        eng_delay = 5;
        stage_job(10, 42, 20, 52, 32'h100, 2, 1);
        avl_write(4'd7, 32'h0, 4'hF);
        pat[0] = engine_execute;
        cfg_run = '0;
        for (int n = 1; n < 7; n++) begin
            @(negedge CLK);
            pat[n] = engine_execute;
            if (n == 1) cfg_run = cfg;
        end
        n_checks++;
        if (pat !== 7'b0111110) $display("[TB] FAIL exec_timing: got %b expected 0111110", pat);
        else n_pass++;
        n_checks++;
        if (cfg_run !== {10'd10, 10'd42, 10'd20, 10'd52, 18'h100, 2'd2, 1'b1})
            $display("[TB] FAIL single_cfg: got %h expected staged job", cfg_run);
        else n_pass++;
        for (int i = 0; i < 50 && busy; i++) @(negedge CLK);
        avl_read(4'd10, rd);
        n_checks++;
        if (rd !== 32'd1) $display("[TB] FAIL single_done_cnt: got %0d expected 1", rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [29:0] order;
        eng_delay = 2;
        avl_write(4'd10, 32'h0, 4'hF);
        start_log.delete();
        avl_write(4'd0, 32'd100, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        avl_write(4'd0, 32'd200, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        avl_write(4'd0, 32'd300, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        for (int i = 0; i < 200 && busy; i++) @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b_drain: got busy=%b expected 0", busy);
        else n_pass++;
        order = '0;
        for (int i = 0; i < 3; i++)
            order = {order[19:0], (i < start_log.size()) ? start_log[i] : 10'h3FF};
        n_checks++;
        if (start_log.size() != 3 || order !== {10'd100, 10'd200, 10'd300})
            $display("[TB] FAIL b2b_order: got %0d starts %h expected 3 starts %h",
                     start_log.size(), order, {10'd100, 10'd200, 10'd300});
        else n_pass++;
        n_checks++;
        if (stable_errs !== 0) $display("[TB] FAIL cfg_stable: got %0d changes under execute expected 0", stable_errs);
        else n_pass++;
        avl_read(4'd10, rd);
        n_checks++;
        if (rd !== 32'd3) $display("[TB] FAIL b2b_done_cnt: got %0d expected 3", rd);
        else n_pass++;
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL b2b_status: got %h expected 00000001", rd);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        eng_delay = 0;
        avl_write(4'd0, 32'd5, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 17; i++) avl_write(4'd7, 32'h0, 4'hF);
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_100E) $display("[TB] FAIL overflow_status: got %h expected 0000100e", rd);
        else n_pass++;
        avl_write(4'd11, 32'h8, 4'hF);
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_1006) $display("[TB] FAIL overflow_clear: got %h expected 00001006", rd);
        else n_pass++;
        avl_write(4'd9, 32'h0, 4'hF);
        for (int i = 0; i < 20 && busy; i++) @(negedge CLK);
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL overflow_flushed: got %h expected 00000001", rd);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        eng_delay = 0;
        for (int i = 0; i < 5; i++) avl_write(4'd7, 32'h0, 4'hF);
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0404 || engine_execute !== 1'b1)
            $display("[TB] FAIL flush_pre: got status %h exec %b expected 00000404 exec 1", rd, engine_execute);
        else n_pass++;
        avl_write(4'd9, 32'h0, 4'hF);
        n_checks++;
        if (engine_execute !== 1'b0) $display("[TB] FAIL flush_exec_drop: got %b expected 0", engine_execute);
        else n_pass++;
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL flush_status: got %h expected 00000001", rd);
        else n_pass++;
        avl_read(4'd10, rd);
        n_checks++;
        if (rd !== 32'd3) $display("[TB] FAIL flush_done_cnt: got %0d expected 3", rd);
        else n_pass++;
        eng_delay = 3;
        avl_write(4'd7, 32'h0, 4'hF);
        for (int i = 0; i < 50 && busy; i++) @(negedge CLK);
        avl_read(4'd10, rd);
        n_checks++;
        if (rd !== 32'd4 || busy !== 1'b0)
            $display("[TB] FAIL flush_next_job: got cnt %0d busy %b expected cnt 4 busy 0", rd, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] rd;
        eng_delay = 0;
        avl_write(4'd7, 32'h0, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({engine_execute, busy} !== 2'b00)
            $display("[TB] FAIL reset_mid_job: got exec=%b busy=%b expected 0 0", engine_execute, busy);
        else n_pass++;
        RESET = 1'b0;
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL reset_mid_status: got %h expected 00000001", rd);
        else n_pass++;
        avl_read(4'd0, rd);
        n_checks++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_mid_staging: got %h expected 00000000", rd);
        else n_pass++;
    endtask

`ifdef COPY_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd;
        eng_delay = 0;
        avl_write(4'd0, 32'd11, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        avl_write(4'd0, 32'd22, 4'hF);
        avl_write(4'd7, 32'h0, 4'hF);
        for (int i = 0; i < 200 && engine_execute; i++) @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (last_run_len !== 50) $display("[TB] FAIL timeout_len: got %0d expected 50", last_run_len);
        else n_pass++;
        avl_read(4'd8, rd);
        n_checks++;
        if (rd[4] !== 1'b1) $display("[TB] FAIL timeout_sticky: got status %h expected bit4 set", rd);
        else n_pass++;
        for (int i = 0; i < 20 && !engine_execute; i++) @(negedge CLK);
        n_checks++;
        if (engine_execute !== 1'b1 || dest_x_start !== 10'd22)
            $display("[TB] FAIL timeout_next_job: got exec %b x %0d expected exec 1 x 22", engine_execute, dest_x_start);
        else n_pass++;
        avl_write(4'd9, 32'h0, 4'hF);
        avl_write(4'd11, 32'h10, 4'hF);
        avl_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL timeout_clear: got %h expected 00000001", rd);
        else n_pass++;
    endtask
`endif

    initial begin
        $display("[TB] starting copy_job_scheduler bench");
        test_reset();
        test_byte_enable();
        test_single_job();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid_job();
`ifdef COPY_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/copy_job_scheduler.md
Name: copy_job_scheduler

Overview:
Avalon-MM job queue that sequences the copy engine. Software stages draw-job fields and pushes them into an internal FIFO. The block pops jobs one at a time and drives the engine's configuration and execute lines. It handles the execute/done handshake per job, so the CPU no longer polls done or clears execute. It sits between the NIOS Avalon bus and the copy engine wrapper's configuration/execute inputs.

Parameters:
DEPTH, 16, job FIFO entries (power of 2, 2..64)
SRC_W, 18, source address width
TIMEOUT_CYCLES, 1000000, watchdog limit per job (used only with the optional feature)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
AVL_READ  in  1  Avalon read
AVL_WRITE  in  1  Avalon write
AVL_CS  in  1  chip select
AVL_BYTE_EN  in  4  byte enables (staging regs only)
AVL_ADDR  in  4  word address
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data
dest_x_start, dest_x_end, dest_y_start, dest_y_end  out  10 each  active job geometry
src_addr_start  out  SRC_W  active job source address
palette_index  out  2  active job palette
flip_x  out  1  active job mirror
engine_execute  out  1  start/hold the engine
engine_done  in  1  engine finished; held high until execute falls
busy  out  1  job active or FIFO non-empty

Behaviour:
- Register map:
  - 0–6: staging registers x_start, x_end, y_start, y_end, src_addr, palette, flip_x. R/W, byte-enabled.
  - 7: write pushes the staged job. Data is ignored.
  - 8: status, RO: [0] empty, [1] full, [2] busy, [3] overflow sticky, [4] timeout sticky, [15:8] count.
  - 9: write performs a flush.
  - 10: completed-job counter, 16-bit wrapping. A write clears it.
  - 11: write 1s to clear the sticky bits in status[4:3].
  - Others read 0.
- AVL_READDATA is combinational from registered state and is 0 when not reading.
- Reset: all staging regs, FIFO pointers, count, counters and sticky bits are 0. State is IDLE. All engine outputs, engine_execute and busy are 0.
- Push:
  - Staged fields are written to the FIFO tail on the write cycle.
  - If the FIFO is full, the job is dropped and the overflow sticky bit is set.
  - Staging registers are unchanged, so repeated pushes are allowed.
- Simultaneous push and pop in one cycle: both occur and count is unchanged. A push into a full FIFO with a same-cycle pop is accepted.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head into the active-job registers and go to RUN. Outputs update the cycle after the pop.
  - RUN: engine_execute = 1. When engine_done = 1, go to RETIRE.
  - RETIRE: engine_execute = 0 and the completed counter increments once. Wait for engine_done = 0, then go to IDLE.
- Back-to-back latency: a job pops 1 cycle after IDLE is entered with a non-empty FIFO.
- The active-job outputs hold their values until the next pop. The engine never sees config change while execute is high.
- Flush:
  - FIFO is emptied and count becomes 0.
  - From RUN, go to RETIRE with execute = 0 (engine force-terminates). No completed-count increment.
  - From IDLE, stay in IDLE.
  - Staging regs are unchanged.
- Reset mid-job: execute drops in the cycle after reset is sampled and the FIFO is cleared.
- busy = (state != IDLE) | !empty.
- count is clog2(DEPTH)+1 bits, zero-extended into status[15:8].

Optional Feature:
COPY_SCHED_TIMEOUT_EN:
- Defined:
  - A per-job cycle counter runs in RUN.
  - On reaching TIMEOUT_CYCLES without done, set the timeout sticky bit and go to RETIRE as an abort. No completed-count increment.
  - The FIFO continues with the next job.
- Undefined: no counter. RUN waits indefinitely and status[4] reads 0.

Decomposition:
- Package copy_sched_pkg:
  - job_t packed struct: 4×10-bit geometry, SRC_W src, 2-bit palette, 1-bit flip.
  - sched_state_t enum: IDLE, RUN, RETIRE.
  - Register address localparams: REG_PUSH=7, REG_STATUS=8, REG_FLUSH=9, REG_DONE_CNT=10, REG_CLR=11.
- Sub-module copy_job_fifo:
  - Synchronous FIFO of job_t, DEPTH deep.
  - Ports: push, pop, flush, full, empty, count, head.
  - Head is show-ahead.

Test Plan:
- Reset, then read status → 0x0000_0001 (empty). All engine outputs 0.
- Stage (x 10..42, y 20..52, src 0x100, pal 2, flip 1) and push. Engine model asserts done 5 cycles after execute:
  - Outputs match the staged job.
  - Execute rises one cycle after the pop and falls the cycle after done.
  - Done counter reads 1.
- Push 3 jobs back-to-back with a 2-cycle engine model:
  - Executed in FIFO order.
  - Execute never high while outputs change.
  - Counter reads 3 and status returns to empty.
- Push DEPTH+1 = 17 jobs with the engine stalled:
  - status count = 16, full = 1, overflow = 1.
  - A write of 0x8 to addr 11 clears overflow.
- Flush during RUN with 4 jobs queued:
  - Execute drops next cycle and count reads 0.
  - Done counter is unchanged.
  - The next push runs normally.
- With COPY_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 50, never assert done:
  - Execute drops after 50 cycles in RUN and the timeout bit is set.
  - The queued second job starts.
